// File: rtl/usb4_clk_en_gen.sv
// rtl/usb4_clk_en_gen.sv - NCO clock-enable generator for USB4 lanes and sideband, with sequenced system reset
// Optional macro USB4_CLK_EN_GEN_GLITCHFREE_SWITCH_EN: per-channel increment changes are applied only at strobe boundaries.
module usb4_clk_en_gen #(
    parameter int          NUM_CH    = 2,
    parameter int          ACC_W     = 32,
    parameter int unsigned SB_INC    = 53687,
    parameter int          RST_TICKS = 3
) (
    input  logic                    local_clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*ACC_W-1:0] ch_inc,
    output logic [NUM_CH-1:0]       ch_stb,
    output logic                    sb_tick,
    output logic                    sys_rst_o,
    output logic                    ready
);

    localparam logic [ACC_W-1:0] SB_INC_W  = ACC_W'(SB_INC);
    localparam logic [7:0]       LAST_TICK = 8'(RST_TICKS - 1);

    typedef enum logic {
        S_HOLD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    logic [ACC_W-1:0] sb_acc_q;
    logic             sb_tick_q;
    logic [ACC_W:0]   sb_sum_d;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             sys_rst_q, sys_rst_d;

    // Sideband NCO runs whenever rst is low, independent of the sequencer.
    assign sb_sum_d = {1'b0, sb_acc_q} + {1'b0, SB_INC_W};

    always_ff @(posedge local_clk) begin
        if (rst) begin
            sb_acc_q  <= '0;
            sb_tick_q <= 1'b0;
        end else begin
            sb_acc_q  <= sb_sum_d[ACC_W-1:0];
            sb_tick_q <= sb_sum_d[ACC_W];
        end
    end

    always_ff @(posedge local_clk) begin
        if (rst) begin
            state_q   <= S_HOLD;
            cnt_q     <= 8'd0;
            sys_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sys_rst_q <= sys_rst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_HOLD && sb_tick_q) begin
            if (cnt_q == LAST_TICK) begin
                state_d = S_RUN;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        sys_rst_d = (state_d == S_HOLD);
    end

    assign sb_tick   = sb_tick_q;
    assign sys_rst_o = sys_rst_q;
    assign ready     = ~sys_rst_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [ACC_W-1:0] acc_q;
        logic             stb_q;
        logic [ACC_W-1:0] inc_d;
        logic [ACC_W:0]   sum_d;
        logic             hold_d;

        assign hold_d = sys_rst_q | ~ch_en[k];

`ifdef USB4_CLK_EN_GEN_GLITCHFREE_SWITCH_EN
        logic [ACC_W-1:0] act_inc_q;

        // Reload only while idle or on a carry so a new rate starts on a strobe boundary.
        always_ff @(posedge local_clk) begin
            if (rst) begin
                act_inc_q <= '0;
            end else if (hold_d || sum_d[ACC_W]) begin
                act_inc_q <= ch_inc[k*ACC_W +: ACC_W];
            end
        end

        assign inc_d = act_inc_q;
`else
        assign inc_d = ch_inc[k*ACC_W +: ACC_W];
`endif

        assign sum_d = {1'b0, acc_q} + {1'b0, inc_d};

        always_ff @(posedge local_clk) begin
            if (rst || hold_d) begin
                acc_q <= '0;
                stb_q <= 1'b0;
            end else begin
                acc_q <= sum_d[ACC_W-1:0];
                stb_q <= sum_d[ACC_W];
            end
        end

        assign ch_stb[k] = stb_q;
    end

endmodule

// File: doc/usb4_clk_en_gen.md
USB4_CLK_EN_GEN -- requirements
Module: usb4_clk_en_gen

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent lane clock-enable channels (1..8).
REQ-002 Parameter ACC_W, default 32: phase-accumulator width in bits (8..48).
REQ-003 Parameter SB_INC, default 53687: fixed sideband increment, 2^32 * 1 MHz / 80 GHz.
REQ-004 Parameter RST_TICKS, default 3: sideband ticks for which sys_rst_o is held after rst releases (1..255).
REQ-005 local_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 ch_en  in  NUM_CH  per-channel run enable.
REQ-008 ch_inc  in  NUM_CH*ACC_W  per-channel phase increment, channel k at bits [k*ACC_W +: ACC_W].
REQ-009 ch_stb  out  NUM_CH  per-channel single-cycle clock-enable strobe.
REQ-010 sb_tick  out  1  single-cycle sideband clock-enable strobe.
REQ-011 sys_rst_o  out  1  sequenced active-high system reset to the logical layer.
REQ-012 ready  out  1  high when sys_rst_o is deasserted; equals ~sys_rst_o.

Function
REQ-013 Each channel and the sideband path SHALL run an NCO: acc <= (acc + inc) mod 2^ACC_W; its strobe register <= the carry-out of that addition.
REQ-014 Strobe latency SHALL be one cycle: a carry produced on edge N gives a strobe high for the cycle after edge N.
REQ-015 Long-run strobe rate SHALL be exactly inc / 2^ACC_W per cycle, with no cumulative drift.
REQ-016 inc = 0 SHALL never strobe; inc = 2^ACC_W-1 SHALL strobe on every cycle except the first.
REQ-017 The sideband NCO SHALL use SB_INC truncated to ACC_W bits, and SHALL run whenever rst is low.
REQ-018 The reset sequencer is a 2-state FSM, HOLD -> RUN: HOLD counts sb_tick pulses in an 8-bit counter; on the cycle sb_tick is high and count = RST_TICKS-1, it moves to RUN; RUN is terminal until rst.
REQ-019 sys_rst_o SHALL be 1 in HOLD and 0 in RUN, registered, and SHALL fall on the edge following the RST_TICKS-th sb_tick.
REQ-020 While sys_rst_o = 1 or ch_en[k] = 0, channel k's accumulator SHALL be held at 0 and ch_stb[k] SHALL be 0.
REQ-021 When ch_en[k] rises, channel k SHALL accumulate from 0 starting at the next edge; when it falls, ch_stb[k] SHALL be 0 from the next cycle.
REQ-022 Channels SHALL be independent; simultaneous strobes on any subset of channels are legal.

Reset
REQ-023 When rst = 1 at an edge: all accumulators 0, ch_stb 0, sb_tick 0, sequencer counter 0, FSM HOLD, sys_rst_o 1, ready 0.
REQ-024 rst asserted mid-operation (including in RUN) SHALL restart the full sequence; no state survives.

Configuration
REQ-025 Macro USB4_CLK_EN_GEN_GLITCHFREE_SWITCH_EN.
- Defined: each channel keeps an active-increment register that loads ch_inc[k] only when (a) that channel produces a carry, (b) ch_en[k] is low, or (c) sys_rst_o is 1. Increment changes therefore take effect at a strobe boundary.
- Undefined: ch_inc[k] is used directly at the next edge, and no active-increment register exists.

Verification
Bench configuration unless noted: NUM_CH=2, ACC_W=8, SB_INC=64, RST_TICKS=3.
REQ-026 Release rst -> sb_tick high in cycles 4, 8, 12; sys_rst_o falls after the cycle-12 edge; ready=1 from cycle 13.
REQ-027 After ready, ch_en=2'b01, ch_inc[0]=128 -> ch_stb[0] high every second cycle, first strobe 2 cycles after enable; ch_stb[1] stays 0.
REQ-028 ch_inc[0]=85 for 256 cycles -> exactly 85 strobes; ch_inc[1]=0 -> 0 strobes.
REQ-029 ch_inc[0] changes 128->64 one cycle after a strobe.
- Macro off: the next strobe arrives 4 cycles after the change.
- Macro on: one more strobe at the old rate, then a 4-cycle period.
REQ-030 rst pulsed for 1 cycle during RUN -> all strobes 0, sys_rst_o=1 immediately; the sequence repeats as in REQ-026.
REQ-031 ch_en[1] dropped for 1 cycle mid-count -> ch_stb[1] 0 during the gap, then phase restarts from 0.
